// File: rtl/cycle_timer_irq_pkg.sv
// Shared constants for the cycle compare/interrupt stage: register map,
// CTRL/STATUS bit positions and FSM state encoding.
package cycle_timer_irq_pkg;

  // Register addresses on the word bus
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_CMP    = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // CTRL register bits
  localparam int CTRL_W         = 3;
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_PER_BIT   = 1;
  localparam int CTRL_IRQEN_BIT = 2;

  // STATUS register bits (read layout and write-1-to-clear layout)
  localparam int STAT_PEND_BIT     = 0;
  localparam int STAT_MISS_CLR_BIT = 1;
  localparam int STAT_MISS_LSB     = 8;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/cycle_cmp_match.sv
// Wrap-safe "count has reached compare" detector: the modular difference
// count - cmp is non-negative when its MSB is clear, which stays correct
// across counter wrap-around as long as the two are within half range.
module cycle_cmp_match
  import cycle_timer_irq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] cmp_i,
  output logic             hit_o
);

  // Only the sign bit of the modular difference matters
  assign hit_o = ((cnt_i - cmp_i) >> (CNT_W - 1)) == '0;

endmodule

// File: rtl/cycle_timer_irq.sv
// Compare/interrupt stage behind the cycle counter. Holds CTRL/CMP/PERIOD,
// a pending flag and a saturating missed-event counter; runs a small
// IDLE/ARMED/DONE FSM for one-shot and auto-reload operation.
module cycle_timer_irq
  import cycle_timer_irq_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int MISS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cycleCnt_i,
  input  logic             we_i,
  input  logic [1:0]       addr_i,
  input  logic [CNT_W-1:0] wdata_i,
  output logic [CNT_W-1:0] rdata_o,
  output logic             irq_o
);

  logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
  logic [CNT_W-1:0]  cmp_q,     cmp_d;
  logic [CNT_W-1:0]  period_q,  period_d;
  logic              pending_q, pending_d;
  logic [MISS_W-1:0] miss_q,    miss_d;
  logic [1:0]        state_q,   state_d;

  logic              hit_s;
  logic              wr_ctrl_s;
  logic              wr_cmp_s;
  logic              wr_period_s;
  logic              wr_status_s;
  logic              pend_clr_s;
  logic              miss_clr_s;
  logic              event_s;
  logic              reload_s;
  logic [CNT_W-1:0]  rdata_s;

  // Saturating increment for the missed-event counter
  function automatic logic [MISS_W-1:0] miss_sat_inc(input logic [MISS_W-1:0] m);
    if (m == {MISS_W{1'b1}}) begin
      return m;
    end else begin
      return m + {{(MISS_W-1){1'b0}}, 1'b1};
    end
  endfunction

  cycle_cmp_match #(.CNT_W(CNT_W)) u_match (
    .cnt_i (cycleCnt_i),
    .cmp_i (cmp_q),
    .hit_o (hit_s)
  );

  assign wr_ctrl_s   = we_i && (addr_i == ADDR_CTRL);
  assign wr_cmp_s    = we_i && (addr_i == ADDR_CMP);
  assign wr_period_s = we_i && (addr_i == ADDR_PERIOD);
  assign wr_status_s = we_i && (addr_i == ADDR_STATUS);
  assign pend_clr_s  = wr_status_s && wdata_i[STAT_PEND_BIT];
  assign miss_clr_s  = wr_status_s && wdata_i[STAT_MISS_CLR_BIT];
  // A CTRL or CMP write in the hit cycle suppresses the event
  assign event_s     = (state_q == ST_ARMED) && hit_s && !wr_ctrl_s && !wr_cmp_s;
  // PERIOD of zero degrades to one-shot so it cannot fire every cycle
  assign reload_s    = ctrl_q[CTRL_PER_BIT] && (period_q != '0);

  // Next-state for registers, FSM, pending flag and miss counter
  always_comb begin
    ctrl_d    = ctrl_q;
    cmp_d     = cmp_q;
    period_d  = period_q;
    pending_d = pending_q;
    miss_d    = miss_q;
    state_d   = state_q;

    if (event_s) begin
      pending_d = 1'b1;
      if (pending_q && !pend_clr_s) begin
        miss_d = miss_sat_inc(miss_q);
      end else begin
        miss_d = miss_q;
      end
      if (reload_s) begin
        cmp_d = cmp_q + period_q;
      end else begin
        state_d = ST_DONE;
      end
    end else if (pend_clr_s) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end

    if (miss_clr_s) begin
      miss_d = '0;
    end else begin
      miss_d = miss_d;
    end

    if (wr_ctrl_s) begin
      ctrl_d  = wdata_i[CTRL_W-1:0];
      state_d = wdata_i[CTRL_EN_BIT] ? ST_ARMED : ST_IDLE;
    end else begin
      ctrl_d = ctrl_q;
    end

    if (wr_cmp_s) begin
      cmp_d = wdata_i;
      if ((state_q == ST_DONE) && ctrl_q[CTRL_EN_BIT]) begin
        state_d = ST_ARMED;
      end else begin
        state_d = state_d;
      end
    end else begin
      cmp_d = cmp_d;
    end

    if (wr_period_s) begin
      period_d = wdata_i;
    end else begin
      period_d = period_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      cmp_q     <= '0;
      period_q  <= '0;
      pending_q <= 1'b0;
      miss_q    <= '0;
      state_q   <= ST_IDLE;
    end else begin
      ctrl_q    <= ctrl_d;
      cmp_q     <= cmp_d;
      period_q  <= period_d;
      pending_q <= pending_d;
      miss_q    <= miss_d;
      state_q   <= state_d;
    end
  end

  // Read mux; unused bits read as zero
  always_comb begin
    rdata_s = '0;
    case (addr_i)
      ADDR_CTRL:   rdata_s[CTRL_W-1:0] = ctrl_q;
      ADDR_CMP:    rdata_s = cmp_q;
      ADDR_PERIOD: rdata_s = period_q;
      ADDR_STATUS: begin
        rdata_s[STAT_PEND_BIT]            = pending_q;
        rdata_s[STAT_MISS_LSB +: MISS_W]  = miss_q;
      end
      default:     rdata_s = '0;
    endcase
  end

  assign rdata_o = rdata_s;
  assign irq_o   = pending_q & ctrl_q[CTRL_IRQEN_BIT];

endmodule

// File: tb/tb_cycle_timer_irq.sv
// Directed bench for cycle_timer_irq: a spec-level model checked every
// cycle, plus hand-computed literal expectations per scenario.
module tb_cycle_timer_irq;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_DONE  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cyc = 32'd0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // model state
  logic [2:0]  m_ctrl;
  logic [31:0] m_cmp, m_period;
  logic        m_pending;
  logic [7:0]  m_miss;
  int          m_mode;

  cycle_timer_irq dut (
    .clk        (clk),
    .rst        (rst),
    .cycleCnt_i (cyc),
    .we_i       (we),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .rdata_o    (rdata),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {29'd0, m_ctrl};
      2'd1:    return m_cmp;
      2'd2:    return m_period;
      default: return {16'd0, m_miss, 7'd0, m_pending};
    endcase
  endfunction

  // Behavioural model: apply the register/timer rules once per clock
  always @(posedge clk) begin
    bit hit, ev, clr;
    if (rst) begin
      m_ctrl = 3'd0; m_cmp = 32'd0; m_period = 32'd0;
      m_pending = 1'b0; m_miss = 8'd0; m_mode = M_IDLE;
    end else begin
      hit = ((cyc - m_cmp) & 32'h8000_0000) == 32'd0;
      ev  = (m_mode == M_ARMED) && hit && !(we && (addr == 2'd0 || addr == 2'd1));
      clr = we && (addr == 2'd3) && wdata[0];
      if (ev) begin
        if (m_pending && !clr && m_miss != 8'hFF) m_miss = m_miss + 8'd1;
        m_pending = 1'b1;
        if (m_ctrl[1] && m_period != 32'd0) m_cmp = m_cmp + m_period;
        else m_mode = M_DONE;
      end else if (clr) begin
        m_pending = 1'b0;
      end
      if (we) begin
        case (addr)
          2'd0: begin
            m_ctrl = wdata[2:0];
            m_mode = wdata[0] ? M_ARMED : M_IDLE;
          end
          2'd1: begin
            m_cmp = wdata;
            if (m_mode == M_DONE && m_ctrl[0]) m_mode = M_ARMED;
          end
          2'd2: m_period = wdata;
          default: if (wdata[1]) m_miss = 8'd0;
        endcase
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if (rdata !== model_read(addr) || irq !== (m_pending & m_ctrl[2])) begin
        n_err++;
        $display("FAIL model t=%0t addr=%0d cyc=%h: got rdata=%h irq=%b, want rdata=%h irq=%b",
                 $time, addr, cyc, rdata, irq, model_read(addr), m_pending & m_ctrl[2]);
      end
    end
  end

  task automatic drive(input logic [31:0] c, input logic w, input logic [1:0] a,
                       input logic [31:0] d);
    @(posedge clk); #2;
    cyc = c; we = w; addr = a; wdata = d;
  endtask

  task automatic lit(input string nm, input logic [1:0] a, input logic [31:0] expv,
                     input logic expirq, input logic [31:0] c);
    drive(c, 1'b0, a, 32'd0);
    @(negedge clk); #1;
    n_vec++;
    if (rdata !== expv || irq !== expirq) begin
      n_err++;
      $display("FAIL %s: got rdata=%h irq=%b, want rdata=%h irq=%b", nm, rdata, irq, expv, expirq);
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #2;
    rst = 1'b1; we = 1'b0;
    repeat (n) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] c;

    // 1. reset values and CTRL masking
    do_reset(2);
    chk_en = 1'b1;
    lit("rst_ctrl",   2'd0, 32'd0, 1'b0, 32'd0);
    lit("rst_cmp",    2'd1, 32'd0, 1'b0, 32'd0);
    lit("rst_period", 2'd2, 32'd0, 1'b0, 32'd0);
    lit("rst_status", 2'd3, 32'd0, 1'b0, 32'd0);
    drive(32'd0, 1'b1, 2'd0, 32'hFFFF_FFF8);
    lit("ctrl_mask", 2'd0, 32'd0, 1'b0, 32'd0);
    drive(32'd0, 1'b1, 2'd2, 32'hDEAD_BEEF);
    lit("period_rw", 2'd2, 32'hDEAD_BEEF, 1'b0, 32'd0);

    // 2. one-shot, ack, no re-fire, then irq_en gating
    do_reset(1);
    drive(32'd0, 1'b1, 2'd1, 32'd100);
    drive(32'd0, 1'b1, 2'd0, 32'd5);
    drive(32'd99, 1'b0, 2'd3, 32'd0);
    drive(32'd100, 1'b0, 2'd3, 32'd0);
    lit("os_fire", 2'd3, 32'd1, 1'b1, 32'd101);
    drive(32'd102, 1'b1, 2'd3, 32'd1);
    for (int i = 103; i <= 200; i++) drive(i, 1'b0, 2'd3, 32'd0);
    lit("os_norefire", 2'd3, 32'd0, 1'b0, 32'd201);
    drive(32'd202, 1'b1, 2'd1, 32'd250);
    drive(32'd203, 1'b1, 2'd0, 32'd1);
    for (int i = 204; i <= 250; i++) drive(i, 1'b0, 2'd3, 32'd0);
    lit("irqen_gate", 2'd3, 32'd1, 1'b0, 32'd251);

    // 3. periodic with misses and ack-on-hit
    do_reset(1);
    drive(32'd0, 1'b1, 2'd1, 32'd10);
    drive(32'd0, 1'b1, 2'd2, 32'd10);
    drive(32'd0, 1'b1, 2'd0, 32'd7);
    for (int i = 1; i <= 39; i++) drive(i, 1'b0, 2'd3, 32'd0);
    drive(32'd40, 1'b1, 2'd3, 32'd1);
    lit("per_ack", 2'd3, 32'h0000_0201, 1'b1, 32'd41);
    lit("per_cmp", 2'd1, 32'd50, 1'b1, 32'd42);
    drive(32'd43, 1'b1, 2'd3, 32'd2);
    lit("per_missclr", 2'd3, 32'd1, 1'b1, 32'd44);

    // 4. wrap-around
    do_reset(1);
    drive(32'hFFFF_FFF0, 1'b1, 2'd1, 32'd5);
    drive(32'hFFFF_FFF0, 1'b1, 2'd0, 32'd1);
    for (int i = 1; i <= 20; i++) begin
      c = 32'hFFFF_FFF0 + i;
      drive(c, 1'b0, 2'd3, 32'd0);
    end
    lit("wrap_pre", 2'd3, 32'd0, 1'b0, 32'd4);
    drive(32'd5, 1'b0, 2'd3, 32'd0);
    lit("wrap_hit", 2'd3, 32'd1, 1'b0, 32'd6);

    // 5. CMP write collides with hit
    do_reset(1);
    drive(32'd0, 1'b1, 2'd1, 32'd300);
    drive(32'd0, 1'b1, 2'd0, 32'd1);
    for (int i = 1; i <= 299; i++) drive(i, 1'b0, 2'd3, 32'd0);
    drive(32'd300, 1'b1, 2'd1, 32'd500);
    lit("coll_none", 2'd3, 32'd0, 1'b0, 32'd301);
    for (int i = 302; i <= 500; i++) drive(i, 1'b0, 2'd3, 32'd0);
    lit("coll_fire", 2'd3, 32'd1, 1'b0, 32'd501);

    // 6. miss saturation, then reset mid-pending
    do_reset(1);
    drive(32'd1000, 1'b1, 2'd1, 32'd10);
    drive(32'd1000, 1'b1, 2'd2, 32'd1);
    drive(32'd1000, 1'b1, 2'd0, 32'd3);
    for (int i = 0; i < 300; i++) drive(32'd1000, 1'b0, 2'd3, 32'd0);
    lit("miss_sat", 2'd3, 32'h0000_FF01, 1'b0, 32'd1000);
    do_reset(1);
    lit("rst_mid_status", 2'd3, 32'd0, 1'b0, 32'd1000);
    lit("rst_mid_cmp",    2'd1, 32'd0, 1'b0, 32'd1000);

    // 7. periodic with PERIOD=0 behaves as one-shot
    do_reset(1);
    drive(32'd0, 1'b1, 2'd1, 32'd5);
    drive(32'd0, 1'b1, 2'd0, 32'd3);
    for (int i = 1; i <= 20; i++) drive(i, 1'b0, 2'd3, 32'd0);
    lit("per0_status", 2'd3, 32'd1, 1'b0, 32'd21);
    lit("per0_cmp",    2'd1, 32'd5, 1'b0, 32'd22);

    drive(32'd0, 1'b0, 2'd0, 32'd0);
    @(posedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
